// File: rtl/i2c_slave_regfile.sv
// Register file behind an I2C slave byte engine: pointer decode, staged per-register
// writes, snapshotted reads. Optional read-only enforcement via I2C_REGFILE_READONLY_EN.
module i2c_slave_regfile #(
  parameter int ADDRESSLENGTH = 8,
  parameter int ADDRESSNUM = 4,
  parameter int NBYTES = 2,
  parameter logic [ADDRESSNUM-1:0] READONLY = '0
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic [ADDRESSLENGTH*ADDRESSNUM-1:0] AddressList,
  input  logic                              Start,
  input  logic                              Stop,
  input  logic                              RxValid,
  input  logic [7:0]                        RxByte,
  input  logic                              TxReq,
  output logic                              RxAck,
  output logic [7:0]                        TxByte,
  output logic                              TxValid,
  output logic                              AddressFound,
  output logic [ADDRESSNUM-1:0]             WriteStrobe,
  output logic [8*NBYTES*ADDRESSNUM-1:0]    DataOut
);

  // state   | meaning
  // IDLE    | bus idle or after STOP, byte events ignored
  // POINTER | after START, next written byte selects a register
  // WRITE   | pointer matched, bytes stage into the current register
  // READ    | transmitting snapshotted register bytes
  // ERROR   | pointer missed, NACK writes and send 0xFF until START/STOP

  localparam int PW = (ADDRESSNUM > 1) ? $clog2(ADDRESSNUM) : 1;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef I2C_REGFILE_READONLY_EN
  localparam logic RO_ENFORCE = 1'b1;
`else
  localparam logic RO_ENFORCE = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_POINTER, S_WRITE, S_READ, S_ERROR} state_t;

  state_t state, state_next;

  logic [PW-1:0]                           ptr;
  logic [PW-1:0]                           ptr_inc;
  logic [CW-1:0]                           cnt;
  logic [NBYTES-1:0][7:0]                  staging;
  logic [NBYTES-1:0][7:0]                  shadow;
  logic [NBYTES-1:0][7:0]                  commit_val;
  logic [ADDRESSNUM-1:0][NBYTES-1:0][7:0]  regs;
  logic                                    hit;
  logic [PW-1:0]                           hit_idx;
  logic                                    ro_cur;
  logic                                    last_byte;

  assign DataOut   = regs;
  assign ro_cur    = RO_ENFORCE & READONLY[ptr];
  assign last_byte = (cnt == CW'(NBYTES - 1));
  assign ptr_inc   = (ptr == PW'(ADDRESSNUM - 1)) ? '0 : ptr + 1'b1;

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = ADDRESSNUM - 1; i >= 0; i--) begin
      if (AddressList[ADDRESSLENGTH*i +: ADDRESSLENGTH] == RxByte[ADDRESSLENGTH-1:0]) begin
        hit = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  always_comb begin
    commit_val = staging;
    commit_val[cnt] = RxByte;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (Start) begin
      state_next = S_POINTER;
    end else if (Stop) begin
      state_next = S_IDLE;
    end else if (state == S_POINTER) begin
      if (RxValid)     state_next = hit ? S_WRITE : S_ERROR;
      else if (TxReq)  state_next = S_READ;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr          <= '0;
      cnt          <= '0;
      staging      <= '0;
      shadow       <= '0;
      regs         <= '0;
      RxAck        <= 1'b0;
      TxByte       <= 8'h00;
      TxValid      <= 1'b0;
      AddressFound <= 1'b0;
      WriteStrobe  <= '0;
    end else begin
      TxValid     <= 1'b0;
      WriteStrobe <= '0;
      if (Start) begin
        cnt     <= '0;
        staging <= '0;
        RxAck   <= 1'b0;
      end else if (Stop) begin
        cnt     <= '0;
        staging <= '0;
      end else if (RxValid) begin
        case (state)
          S_POINTER: begin
            AddressFound <= hit;
            RxAck        <= hit;
            if (hit) ptr <= hit_idx;
          end
          S_WRITE: begin
            RxAck <= ~ro_cur;
            if (!ro_cur) staging[cnt] <= RxByte;
            if (last_byte) begin
              if (!ro_cur) begin
                regs[ptr]        <= commit_val;
                WriteStrobe[ptr] <= 1'b1;
              end
              cnt <= '0;
              ptr <= ptr_inc;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: RxAck <= 1'b0;
        endcase
      end else if (TxReq) begin
        case (state)
          S_POINTER, S_READ: begin
            TxValid <= 1'b1;
            // Snapshot at byte 0 keeps a multi-byte read coherent.
            if (cnt == '0) begin
              shadow <= regs[ptr];
              TxByte <= regs[ptr][0];
            end else begin
              TxByte <= shadow[cnt];
            end
            if (last_byte) begin
              cnt <= '0;
              ptr <= ptr_inc;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_ERROR: begin
            TxValid <= 1'b1;
            TxByte  <= 8'hFF;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: directed plan steps followed by random
// byte events compared against a transaction-level model of the register file.
module tb_i2c_slave_regfile;

  localparam int AN = 4;
  localparam int NB = 2;
  localparam logic [AN-1:0] RO_MASK = 4'b0100;
`ifdef I2C_REGFILE_READONLY_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  localparam int K_START = 0, K_STOP = 1, K_RX = 2, K_TX = 3, K_START_RX = 4, K_IDLE = 5;
  localparam int M_IDLE = 0, M_PTR = 1, M_WR = 2, M_RD = 3, M_ERR = 4;

  logic        Clk, Reset, Start, Stop, RxValid, TxReq;
  logic [31:0] AddressList;
  logic [7:0]  RxByte;
  logic        RxAck, TxValid, AddressFound;
  logic [7:0]  TxByte;
  logic [AN-1:0] WriteStrobe;
  logic [63:0] DataOut;

  i2c_slave_regfile #(
    .ADDRESSLENGTH(8), .ADDRESSNUM(AN), .NBYTES(NB), .READONLY(RO_MASK)
  ) dut (
    .Clk(Clk), .Reset(Reset), .AddressList(AddressList), .Start(Start), .Stop(Stop),
    .RxValid(RxValid), .RxByte(RxByte), .TxReq(TxReq), .RxAck(RxAck), .TxByte(TxByte),
    .TxValid(TxValid), .AddressFound(AddressFound), .WriteStrobe(WriteStrobe), .DataOut(DataOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_assert = 0;
  int n_fail = 0;

  // Transaction-level reference
  logic [15:0] m_reg [AN];
  logic [7:0]  m_bytes [NB];
  logic [15:0] m_shadow;
  int          m_mode, m_ptr, m_cnt;
  logic        m_ack, m_found, m_txv;
  logic [7:0]  m_tx;
  logic [AN-1:0] m_strobe;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < AN; i++) m_reg[i] = '0;
    m_shadow = '0; m_mode = M_IDLE; m_ptr = 0; m_cnt = 0;
    m_ack = 0; m_found = 0; m_txv = 0; m_tx = 8'h00; m_strobe = '0;
  endtask

  task automatic model_step(input int kind, input logic [7:0] b);
    bit ro;
    int idx;
    m_strobe = '0;
    m_txv = 0;
    if (kind == K_START || kind == K_START_RX) begin
      m_mode = M_PTR; m_cnt = 0; m_ack = 0;
    end else if (kind == K_STOP) begin
      m_mode = M_IDLE; m_cnt = 0;
    end else if (kind == K_RX) begin
      if (m_mode == M_PTR) begin
        idx = -1;
        for (int i = 0; i < AN; i++)
          if (idx < 0 && AddressList[8*i +: 8] == b) idx = i;
        if (idx >= 0) begin
          m_ptr = idx; m_found = 1; m_ack = 1; m_mode = M_WR;
        end else begin
          m_found = 0; m_ack = 0; m_mode = M_ERR;
        end
      end else if (m_mode == M_WR) begin
        ro = RO_EN && RO_MASK[m_ptr];
        m_ack = !ro;
        if (!ro) m_bytes[m_cnt] = b;
        if (m_cnt == NB - 1) begin
          if (!ro) begin
            m_reg[m_ptr] = {m_bytes[1], m_bytes[0]};
            m_strobe = AN'(1) << m_ptr;
          end
          m_cnt = 0;
          m_ptr = (m_ptr + 1) % AN;
        end else m_cnt++;
      end else begin
        m_ack = 0;
      end
    end else if (kind == K_TX) begin
      if (m_mode == M_PTR || m_mode == M_RD) begin
        m_mode = M_RD;
        m_txv = 1;
        if (m_cnt == 0) m_shadow = m_reg[m_ptr];
        m_tx = m_shadow[8*m_cnt +: 8];
        if (m_cnt == NB - 1) begin
          m_cnt = 0;
          m_ptr = (m_ptr + 1) % AN;
        end else m_cnt++;
      end else if (m_mode == M_ERR) begin
        m_txv = 1;
        m_tx = 8'hFF;
      end
    end
  endtask

  task automatic check_all();
    chk("rxack", 64'(RxAck), 64'(m_ack));
    chk("found", 64'(AddressFound), 64'(m_found));
    chk("strobe", 64'(WriteStrobe), 64'(m_strobe));
    chk("dataout", DataOut, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
    chk("txvalid", 64'(TxValid), 64'(m_txv));
    chk("txbyte", 64'(TxByte), 64'(m_tx));
  endtask

  // Called at a falling edge; events issued back to back occupy consecutive cycles.
  task automatic ev(input int kind, input logic [7:0] b);
    Start   = (kind == K_START || kind == K_START_RX);
    Stop    = (kind == K_STOP);
    RxValid = (kind == K_RX || kind == K_START_RX);
    TxReq   = (kind == K_TX);
    RxByte  = b;
    @(negedge Clk);
    Start = 0; Stop = 0; RxValid = 0; TxReq = 0;
    model_step(kind, b);
    check_all();
  endtask

  task automatic do_reset();
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    model_reset();
    check_all();
  endtask

  initial begin
    int r;
    logic [7:0] b;
    Reset = 1; Start = 0; Stop = 0; RxValid = 0; TxReq = 0; RxByte = 8'h00;
    AddressList = 32'h1312_1110;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 0;
    check_all();

    // Write register 1
    ev(K_START, 0); ev(K_RX, 8'h11);
    chk("wr_found", 64'(AddressFound), 64'd1);
    ev(K_RX, 8'hAA); ev(K_RX, 8'h55);
    chk("wr_strobe", 64'(WriteStrobe), 64'b0010);
    chk("wr_reg1", 64'(DataOut[31:16]), 64'h55AA);
    ev(K_STOP, 0);

    // Aborted write, then reset mid-register
    ev(K_START, 0); ev(K_RX, 8'h10); ev(K_RX, 8'h77); ev(K_STOP, 0);
    chk("abort_reg0", 64'(DataOut[15:0]), 64'h0000);
    ev(K_START, 0); ev(K_RX, 8'h13); ev(K_RX, 8'h99);
    do_reset();
    chk("rst_dataout", DataOut, 64'h0);
    ev(K_RX, 8'h42); ev(K_TX, 0);
    ev(K_START, 0); ev(K_RX, 8'h11); ev(K_RX, 8'hAA); ev(K_RX, 8'h55); ev(K_STOP, 0);

    // Pointer miss
    ev(K_START, 0); ev(K_RX, 8'h20);
    chk("miss_ack", 64'(RxAck), 64'd0);
    ev(K_RX, 8'h01); ev(K_TX, 0);
    chk("miss_tx", 64'(TxByte), 64'hFF);
    ev(K_STOP, 0);

    // Auto-increment wrap
    ev(K_START, 0); ev(K_RX, 8'h13); ev(K_RX, 8'h01); ev(K_RX, 8'h02);
    chk("wrap_strobe3", 64'(WriteStrobe), 64'b1000);
    ev(K_RX, 8'h03); ev(K_RX, 8'h04);
    chk("wrap_strobe0", 64'(WriteStrobe), 64'b0001);
    chk("wrap_regs", {DataOut[63:48], DataOut[15:0]}, 64'h0201_0403);
    ev(K_STOP, 0);

    // Read across a register boundary
    ev(K_START, 0); ev(K_RX, 8'h12); ev(K_RX, 8'h34); ev(K_RX, 8'h12); ev(K_STOP, 0);
    ev(K_START, 0); ev(K_RX, 8'h11); ev(K_START, 0);
    ev(K_TX, 0); chk("rd_b0", 64'(TxByte), 64'hAA);
    ev(K_TX, 0); chk("rd_b1", 64'(TxByte), 64'h55);
    ev(K_TX, 0); chk("rd_b2", 64'(TxByte), RO_EN ? 64'h00 : 64'h34);
    ev(K_STOP, 0);

    // Read-only register 2
    ev(K_START, 0); ev(K_RX, 8'h12); ev(K_RX, 8'hEE); ev(K_RX, 8'hFF);
    chk("ro_strobe", 64'(WriteStrobe), RO_EN ? 64'b0000 : 64'b0100);
    chk("ro_reg2", 64'(DataOut[47:32]), RO_EN ? 64'h0000 : 64'hFFEE);
    ev(K_STOP, 0);

    // Start coincident with a byte: the byte is dropped
    ev(K_START_RX, 8'h10);
    ev(K_RX, 8'h10);

    // Random event stream
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (m_mode == M_PTR) b = 8'h10 + 8'($urandom_range(0, 4));
      else b = 8'($urandom);
      if (r < 7) ev(K_START, 0);
      else if (r < 11) ev(K_STOP, 0);
      else if (r < 13) ev(K_START_RX, b);
      else if (r < 14) do_reset();
      else if (r < 60) ev(K_RX, b);
      else if (r < 92) ev(K_TX, 0);
      else ev(K_IDLE, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
# i2c_slave_regfile

Parametrised, synchronous register file behind the I2C slave byte engine. It consumes byte-level events (START, STOP, received byte, transmit request), decodes the first written byte as a register pointer against a configurable address list, and auto-increments across multi-byte registers. Writes are staged and committed atomically per register, and reads are snapshotted per register. All register contents are exposed in parallel to the system side.

## Interface
- ADDRESSLENGTH, 8: register-pointer width in bits.
- ADDRESSNUM, 4: number of registers.
- NBYTES, 2: bytes per register.
- READONLY, 0: ADDRESSNUM-bit mask; bit i=1 makes register i read-only (see Configuration).

- Clk  in  1  single clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- AddressList  in  ADDRESSLENGTH*ADDRESSNUM  entry i at [ADDRESSLENGTH*i +: ADDRESSLENGTH].
- Start  in  1  one-cycle pulse, START or repeated START.
- Stop  in  1  one-cycle pulse, STOP.
- RxValid  in  1  one-cycle pulse, RxByte valid (bytes after device address only).
- RxByte  in  8  received byte.
- TxReq  in  1  one-cycle pulse, engine needs next byte to transmit.
- RxAck  out  1  1=ACK, 0=NACK for last RxByte.
- TxByte  out  8  byte to transmit.
- TxValid  out  1  one-cycle pulse, TxByte valid.
- AddressFound  out  1  last pointer byte matched an entry.
- WriteStrobe  out  ADDRESSNUM  one-hot pulse on register commit.
- DataOut  out  8*NBYTES*ADDRESSNUM  register i at [8*NBYTES*i +: 8*NBYTES]; byte k at +8k.

## Operation
- State: Pointer (index 0..ADDRESSNUM-1), ByteCounter (0..NBYTES-1), FSM {IDLE, POINTER, WRITE, READ, ERROR}, staging register (8*NBYTES), read shadow (8*NBYTES).
- Byte 0 of a register is least significant and is transferred first.
- IDLE/any state + Start -> POINTER; ByteCounter<=0; staging discarded.
- Stop from any state -> IDLE; staging discarded; Pointer retained.
- POINTER + RxValid: match RxByte[ADDRESSLENGTH-1:0] against AddressList, lowest index wins.
  - Hit -> Pointer<=index, AddressFound<=1, RxAck<=1, -> WRITE.
  - Miss -> AddressFound<=0, RxAck<=0, -> ERROR.
- POINTER + TxReq -> READ, using the current Pointer.
- WRITE + RxValid:
  - Read-only register -> RxAck<=0; byte dropped; ByteCounter still advances.
  - Otherwise -> staging byte ByteCounter<=RxByte, RxAck<=1.
  - At ByteCounter==NBYTES-1: commit staging to register Pointer (writable only), WriteStrobe[Pointer] pulses, ByteCounter<=0, Pointer<=Pointer+1 wrapping ADDRESSNUM-1 -> 0.
- READ + TxReq:
  - ByteCounter==0 -> shadow<=register Pointer; TxByte<=its byte 0.
  - Otherwise TxByte<=shadow byte ByteCounter.
  - Last byte -> ByteCounter<=0, Pointer increments with wrap.
- READ + RxValid: RxAck<=0, byte ignored.
- ERROR: every RxValid gives RxAck<=0; every TxReq gives TxByte<=8'hFF. Exit only on Start or Stop.
- Start and Stop have priority over RxValid/TxReq in the same cycle; a coincident byte event is ignored.

## Timing
- Reset values: RxAck 0, TxByte 8'h00, TxValid 0, AddressFound 0, WriteStrobe 0, DataOut 0, Pointer 0, ByteCounter 0, FSM IDLE.
- RxAck is registered: valid the cycle after RxValid, held until the next RxValid, Start or Reset (Start clears it to 0).
- TxByte/TxValid are registered one cycle after TxReq. TxByte holds until the next TxReq.
- WriteStrobe and DataOut update in the same cycle, one cycle after the final RxValid of a register.
- The read snapshot is taken at the first byte. Commits landing on register Pointer mid-read do not alter remaining bytes.
- Reset mid-transaction: everything returns to reset values next edge, including DataOut.
- Back-to-back events every cycle are supported.

## Configuration
- I2C_REGFILE_READONLY_EN defined: READONLY mask is enforced. Writes to masked registers NACK per byte and never commit or strobe.
- Not defined: READONLY is ignored; all registers are writable.

## Test plan
Common setup: ADDRESSNUM=4, NBYTES=2, AddressList entries 0..3 = 0x10, 0x11, 0x12, 0x13.
- Write: Start, Rx 0x11, 0xAA, 0x55, Stop -> RxAck=1 ×3, AddressFound=1, WriteStrobe=4'b0010 one cycle after 0x55, DataOut[31:16]=16'h55AA.
- Aborted write: Start, Rx 0x10, 0x77, Stop -> no WriteStrobe, DataOut[15:0] unchanged. Reset asserted mid-register -> DataOut=0, FSM IDLE.
- Miss: Start, Rx 0x20, 0x01, then TxReq -> RxAck=0 ×2, AddressFound=0, TxByte=8'hFF, DataOut unchanged.
- Auto-increment wrap: Start, Rx 0x13, 01, 02, 03, 04 -> WriteStrobe 4'b1000 then 4'b0001, reg3=16'h0201, reg0=16'h0403.
- Read: reg1=16'h55AA, reg2=16'h1234. Start, Rx 0x11, Start, TxReq ×3 -> TxByte 0xAA, 0x55, 0x34, each one cycle after its TxReq.
- READONLY=4'b0100, Rx 0x12, 0xEE, 0xFF:
  - With macro -> data RxAck=0, no strobe, reg2 unchanged.
  - Without macro -> ACK, WriteStrobe=4'b0100, reg2=16'hFFEE.
